alu_uart_sequencer: RTL and testbench

Sequences the ALU from a serial byte stream. It collects operand A, operand B and the opcode from the UART receiver, then commits all three to the ALU operand registers in one cycle. After the ALU latency it captures the result and hands it to the UART transmitter. It replaces button/switch loading of the ALU registers and sits between uart_rx/uart_tx and the ALU.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/frame_timeout_timer.sv | 38 +++
 rtl/alu_uart_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_alu_uart_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode values, sequencer state encoding and error codes.
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        SEND,
        WAIT_TX
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_TIMEOUT = 2'b01,
        ERR_BADOP   = 2'b10,
        ERR_OVERRUN = 2'b11
    } err_e;

    // Caller is responsible for checking that the opcode byte's upper bits are zero.
    function automatic logic is_valid_op(input int unsigned op);
        case (op)
            32'(OP_ADD), 32'(OP_SUB), 32'(OP_AND), 32'(OP_OR),
            32'(OP_XOR), 32'(OP_NOR), 32'(OP_SRA), 32'(OP_SRL): is_valid_op = 1'b1;
            default:                                            is_valid_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/frame_timeout_timer.sv
// Inter-byte idle timer: counts enabled cycles since the last clear and flags the terminal cycle.
module frame_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // A clear in the terminal cycle (byte arrived) suppresses expiry.
    assign expired = (TIMEOUT_CYCLES > 0) && enable && !clear && (cnt_q == LAST);

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_uart_sequencer.sv
// Collects A, B and opcode bytes from the UART, commits them to the ALU together,
// then returns the ALU result through the UART transmitter.
module alu_uart_sequencer
    import alu_pkg::*;
#(
    parameter int N_DATA         = 8,
    parameter int N_OP           = 6,
    parameter int ALU_LAT        = 1,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_DATA-1:0] i_rx_data,
    input  logic              i_rx_done,
    input  logic              i_tx_done,
    input  logic [N_DATA-1:0] i_alu_res,
    output logic [N_DATA-1:0] o_A,
    output logic [N_DATA-1:0] o_B,
    output logic [N_OP-1:0]   o_OP,
    output logic [N_DATA-1:0] o_tx_data,
    output logic              o_tx_start,
    output logic              o_busy,
    output logic              o_error,
    output logic [1:0]        o_err_code
);

    localparam int EW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [EW-1:0] EXEC_LAST = EW'(ALU_LAT - 1);

    state_e            state_q, state_d;
    logic [N_DATA-1:0] a_stage_q, a_stage_d;
    logic [N_DATA-1:0] b_stage_q, b_stage_d;
    logic [N_DATA-1:0] op_a_q, op_a_d;
    logic [N_DATA-1:0] op_b_q, op_b_d;
    logic [N_OP-1:0]   opc_q, opc_d;
    logic [N_DATA-1:0] tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              busy_q, busy_d;
    logic              error_q, error_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [EW-1:0]     exec_cnt_q, exec_cnt_d;

    logic in_frame;
    logic expired;
    logic op_ok;

    assign in_frame = (state_q == WAIT_B) || (state_q == WAIT_OP);
    assign op_ok    = ((i_rx_data >> N_OP) == '0) && is_valid_op(32'(i_rx_data[N_OP-1:0]));

    frame_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (!in_frame || i_rx_done),
        .enable (in_frame),
        .expired(expired)
    );

    always_comb begin
        state_d    = state_q;
        a_stage_d  = a_stage_q;
        b_stage_d  = b_stage_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        opc_d      = opc_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        error_d    = 1'b0;
        err_code_d = err_code_q;
        exec_cnt_d = exec_cnt_q;

        case (state_q)
            WAIT_A: begin
                if (i_rx_done) begin
                    a_stage_d = i_rx_data;
                    state_d   = WAIT_B;
                end
            end
            WAIT_B: begin
                if (i_rx_done) begin
                    b_stage_d = i_rx_data;
                    state_d   = WAIT_OP;
                end else if (expired) begin
                    error_d    = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    a_stage_d  = '0;
                    b_stage_d  = '0;
                    state_d    = WAIT_A;
                end
            end
            WAIT_OP: begin
                if (i_rx_done) begin
                    if (op_ok) begin
                        op_a_d     = a_stage_q;
                        op_b_d     = b_stage_q;
                        opc_d      = i_rx_data[N_OP-1:0];
                        exec_cnt_d = '0;
                        state_d    = EXEC;
                    end else begin
                        error_d    = 1'b1;
                        err_code_d = ERR_BADOP;
                        state_d    = WAIT_A;
                    end
                end else if (expired) begin
                    error_d    = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    a_stage_d  = '0;
                    b_stage_d  = '0;
                    state_d    = WAIT_A;
                end
            end
            EXEC: begin
                // tx_start and the code clear are registered so they coincide with SEND.
                if (exec_cnt_q == EXEC_LAST) begin
                    tx_data_d  = i_alu_res;
                    tx_start_d = 1'b1;
                    err_code_d = ERR_NONE;
                    state_d    = SEND;
                end else begin
                    exec_cnt_d = exec_cnt_q + EW'(1);
                end
            end
            SEND: begin
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (i_tx_done) begin
                    state_d = WAIT_A;
                end
            end
            default: begin
                state_d = WAIT_A;
            end
        endcase

        if (i_rx_done && ((state_q == EXEC) || (state_q == SEND) || (state_q == WAIT_TX))) begin
            error_d    = 1'b1;
            err_code_d = ERR_OVERRUN;
        end

        busy_d = (state_d == EXEC) || (state_d == SEND) || (state_d == WAIT_TX);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= WAIT_A;
            a_stage_q  <= '0;
            b_stage_q  <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            opc_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
            exec_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            a_stage_q  <= a_stage_d;
            b_stage_q  <= b_stage_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            opc_q      <= opc_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            exec_cnt_q <= exec_cnt_d;
        end
    end

    assign o_A        = op_a_q;
    assign o_B        = op_b_q;
    assign o_OP       = opc_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_busy     = busy_q;
    assign o_error    = error_q;
    assign o_err_code = err_code_q;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Directed bench for alu_uart_sequencer: frame table plus reset, timeout and overrun sequences.
module tb_alu_uart_sequencer;

    logic       clock;
    logic       reset;
    logic [7:0] i_rx_data;
    logic       i_rx_done;
    logic       i_tx_done;
    logic [7:0] i_alu_res;
    logic [7:0] o_A;
    logic [7:0] o_B;
    logic [5:0] o_OP;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       o_busy;
    logic       o_error;
    logic [1:0] o_err_code;

    int total;
    int bad;

    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic [5:0] exp_op;

    alu_uart_sequencer #(
        .N_DATA(8),
        .N_OP(6),
        .ALU_LAT(1),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .i_rx_data (i_rx_data),
        .i_rx_done (i_rx_done),
        .i_tx_done (i_tx_done),
        .i_alu_res (i_alu_res),
        .o_A       (o_A),
        .o_B       (o_B),
        .o_OP      (o_OP),
        .o_tx_data (o_tx_data),
        .o_tx_start(o_tx_start),
        .o_busy    (o_busy),
        .o_error   (o_error),
        .o_err_code(o_err_code)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stand-in ALU: combinational on the registered operands.
    always_comb begin
        case (o_OP)
            6'h20:   i_alu_res = o_A + o_B;
            6'h22:   i_alu_res = o_A - o_B;
            6'h24:   i_alu_res = o_A & o_B;
            6'h25:   i_alu_res = o_A | o_B;
            6'h26:   i_alu_res = o_A ^ o_B;
            6'h27:   i_alu_res = ~(o_A | o_B);
            6'h03:   i_alu_res = 8'($signed(o_A) >>> o_B[2:0]);
            6'h02:   i_alu_res = o_A >> o_B[2:0];
            default: i_alu_res = 8'h00;
        endcase
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [7:0] res;
        bit         valid;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        tick();
        i_rx_done = 1'b0;
    endtask

    task automatic frame_valid(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                               input logic [7:0] res, input bit finish_tx);
        send_byte(a);
        send_byte(b);
        check("operand A held before commit", 32'(o_A), 32'(exp_a));
        send_byte(op);
        exp_a  = a;
        exp_b  = b;
        exp_op = op[5:0];
        check("commit A", 32'(o_A), 32'(a));
        check("commit B", 32'(o_B), 32'(b));
        check("commit OP", 32'(o_OP), 32'(op[5:0]));
        check("busy in exec", 32'(o_busy), 32'd1);
        check("no tx_start in exec", 32'(o_tx_start), 32'd0);
        tick();
        check("tx_start in send", 32'(o_tx_start), 32'd1);
        check("tx_data result", 32'(o_tx_data), 32'(res));
        check("err_code cleared in send", 32'(o_err_code), 32'd0);
        tick();
        check("tx_start single pulse", 32'(o_tx_start), 32'd0);
        check("busy in wait_tx", 32'(o_busy), 32'd1);
        if (finish_tx) begin
            i_tx_done = 1'b1;
            tick();
            i_tx_done = 1'b0;
            check("idle after tx_done", 32'(o_busy), 32'd0);
        end
    endtask

    task automatic frame_invalid(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        int starts;
        send_byte(a);
        send_byte(b);
        send_byte(op);
        check("badop error pulse", 32'(o_error), 32'd1);
        check("badop err_code", 32'(o_err_code), 32'd2);
        check("badop A unchanged", 32'(o_A), 32'(exp_a));
        check("badop B unchanged", 32'(o_B), 32'(exp_b));
        check("badop OP unchanged", 32'(o_OP), 32'(exp_op));
        check("badop not busy", 32'(o_busy), 32'd0);
        starts = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (o_tx_start) starts++;
        end
        check("badop no tx_start", 32'(starts), 32'd0);
        check("badop error one cycle", 32'(o_error), 32'd0);
        check("badop err_code held", 32'(o_err_code), 32'd2);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        exp_a     = 8'h00;
        exp_b     = 8'h00;
        exp_op    = 6'h00;
        reset     = 1'b0;
        i_rx_data = 8'h55;
        i_rx_done = 1'b1;
        i_tx_done = 1'b1;

        vecs[0] = '{a: 8'h05, b: 8'h03, op: 8'h20, res: 8'h08, valid: 1'b1};
        vecs[1] = '{a: 8'h07, b: 8'h01, op: 8'h3F, res: 8'h00, valid: 1'b0};
        vecs[2] = '{a: 8'h09, b: 8'h04, op: 8'h22, res: 8'h05, valid: 1'b1};
        vecs[3] = '{a: 8'h0F, b: 8'h33, op: 8'h24, res: 8'h03, valid: 1'b1};
        vecs[4] = '{a: 8'h0F, b: 8'h30, op: 8'h25, res: 8'h3F, valid: 1'b1};
        vecs[5] = '{a: 8'hFF, b: 8'h0F, op: 8'h26, res: 8'hF0, valid: 1'b1};
        vecs[6] = '{a: 8'h12, b: 8'h34, op: 8'h60, res: 8'h00, valid: 1'b0};
        vecs[7] = '{a: 8'h00, b: 8'h00, op: 8'h27, res: 8'hFF, valid: 1'b1};
        vecs[8] = '{a: 8'h80, b: 8'h02, op: 8'h03, res: 8'hE0, valid: 1'b1};
        vecs[9] = '{a: 8'h80, b: 8'h02, op: 8'h02, res: 8'h20, valid: 1'b1};

        // Reset held with strobes active
        for (int i = 0; i < 3; i++) tick();
        check("reset o_A", 32'(o_A), 32'd0);
        check("reset o_B", 32'(o_B), 32'd0);
        check("reset o_OP", 32'(o_OP), 32'd0);
        check("reset o_tx_data", 32'(o_tx_data), 32'd0);
        check("reset o_tx_start", 32'(o_tx_start), 32'd0);
        check("reset o_busy", 32'(o_busy), 32'd0);
        check("reset o_error", 32'(o_error), 32'd0);
        check("reset o_err_code", 32'(o_err_code), 32'd0);
        i_rx_done = 1'b0;
        i_tx_done = 1'b0;
        reset     = 1'b1;
        tick();
        check("idle after reset", 32'(o_busy), 32'd0);
        check("no error after reset", 32'(o_error), 32'd0);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].valid) frame_valid(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, 1'b1);
            else               frame_invalid(vecs[i].a, vecs[i].b, vecs[i].op);
        end

        // Timeout after A with silence
        send_byte(8'h11);
        for (int i = 0; i < 15; i++) tick();
        check("no timeout before terminal", 32'(o_error), 32'd0);
        tick();
        check("timeout error pulse", 32'(o_error), 32'd1);
        check("timeout err_code", 32'(o_err_code), 32'd1);
        check("timeout not busy", 32'(o_busy), 32'd0);
        tick();
        check("timeout error one cycle", 32'(o_error), 32'd0);

        // Strobe on the terminal cycle is accepted as B
        send_byte(8'h11);
        for (int i = 0; i < 15; i++) tick();
        send_byte(8'h02);
        check("terminal strobe no error", 32'(o_error), 32'd0);
        check("err_code still timeout", 32'(o_err_code), 32'd1);
        send_byte(8'h20);
        check("terminal B committed", 32'(o_B), 32'd2);
        check("terminal A committed", 32'(o_A), 32'h11);
        exp_a = 8'h11;
        exp_b = 8'h02;
        exp_op = 6'h20;
        tick();
        check("terminal frame tx_start", 32'(o_tx_start), 32'd1);
        check("terminal frame result", 32'(o_tx_data), 32'h13);
        check("terminal frame err_code cleared", 32'(o_err_code), 32'd0);
        tick();
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        check("terminal frame idle", 32'(o_busy), 32'd0);

        // Overrun during WAIT_TX, then coincident with tx_done
        frame_valid(8'h06, 8'h02, 8'h22, 8'h04, 1'b0);
        send_byte(8'hAA);
        check("overrun error pulse", 32'(o_error), 32'd1);
        check("overrun err_code", 32'(o_err_code), 32'd3);
        check("overrun still busy", 32'(o_busy), 32'd1);
        check("overrun A untouched", 32'(o_A), 32'h06);
        tick();
        check("overrun error one cycle", 32'(o_error), 32'd0);
        check("overrun state kept", 32'(o_busy), 32'd1);
        i_tx_done = 1'b1;
        send_byte(8'hBB);
        i_tx_done = 1'b0;
        check("coincident overrun error", 32'(o_error), 32'd1);
        check("coincident overrun code", 32'(o_err_code), 32'd3);
        check("coincident tx_done idles", 32'(o_busy), 32'd0);
        tick();
        frame_valid(8'h01, 8'h01, 8'h20, 8'h02, 1'b1);

        // Reset in WAIT_TX
        frame_valid(8'h21, 8'h03, 8'h20, 8'h24, 1'b0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("reset in wait_tx tx_start", 32'(o_tx_start), 32'd0);
        check("reset in wait_tx busy", 32'(o_busy), 32'd0);
        check("reset in wait_tx o_A", 32'(o_A), 32'd0);
        exp_a = 8'h00;
        exp_b = 8'h00;
        exp_op = 6'h00;

        // Reset in WAIT_OP
        send_byte(8'h44);
        send_byte(8'h55);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("reset in wait_op tx_start", 32'(o_tx_start), 32'd0);
        check("reset in wait_op busy", 32'(o_busy), 32'd0);
        frame_valid(8'h02, 8'h03, 8'h20, 8'h05, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
